my_progloader: RTL and testbench

Program loader for the 16-bit CPU's byte-wide instruction memory. Accepts a length-prefixed byte stream from a host over a valid/ready handshake and writes it to ascending memory addresses from 0. Holds the CPU stalled until the image is completely written, then releases it. It is the writer side of the instruction memory that the CPU fetch path reads as big-endian {mem[PC], mem[PC+1]}.

---
 rtl/my_progloader.sv | 126 ++++++++++++
 tb/tb_my_progloader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/my_progloader.sv
// Program loader: length-prefixed byte stream -> instruction memory writes, holds the CPU until loaded.
// Define MY_PROGLOADER_CHKSUM_EN to require a trailing zero-sum checksum byte after the image.
module my_progloader #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [7:0]        IN_DATA,
  output logic              IN_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [7:0]        WDATA,
  output logic              BUSY,
  output logic              CPU_RUN,
  output logic              ERR
);

`ifdef MY_PROGLOADER_CHKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CHK, ST_DONE, ST_FAIL} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_FAIL} state_t;
`endif

  localparam logic [7:0] MAX_LEN = 8'(MEM_BYTES);

  state_t            state, state_next;
  logic [7:0]        remaining;
  logic [ADDR_W-1:0] next_addr;
  logic              len_bad;

  assign len_bad = (IN_DATA == 8'd0) || IN_DATA[0] || (IN_DATA > MAX_LEN);

`ifdef MY_PROGLOADER_CHKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_total;
  assign sum_total = sum + IN_DATA;
`endif

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Handshake and status outputs decode the registered state only.
  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    BUSY       = 1'b0;
    CPU_RUN    = 1'b0;
    ERR        = 1'b0;
    case (state)
      ST_IDLE: if (START) state_next = ST_LEN;
      ST_LEN: begin
        IN_READY = 1'b1;
        BUSY     = 1'b1;
        if (IN_VALID) state_next = len_bad ? ST_FAIL : ST_DATA;
      end
      ST_DATA: begin
        IN_READY = 1'b1;
        BUSY     = 1'b1;
        if (IN_VALID && remaining == 8'd1) begin
`ifdef MY_PROGLOADER_CHKSUM_EN
          state_next = ST_CHK;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef MY_PROGLOADER_CHKSUM_EN
      ST_CHK: begin
        IN_READY = 1'b1;
        BUSY     = 1'b1;
        if (IN_VALID) state_next = (sum_total == 8'd0) ? ST_DONE : ST_FAIL;
      end
`endif
      ST_DONE: begin
        CPU_RUN = 1'b1;
        if (START) state_next = ST_LEN;
      end
      ST_FAIL: begin
        ERR = 1'b1;
        if (START) state_next = ST_LEN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write port is registered: a byte accepted at edge E is presented during E..E+1.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      remaining <= '0;
      next_addr <= '0;
      WE        <= 1'b0;
      WADDR     <= '0;
      WDATA     <= '0;
`ifdef MY_PROGLOADER_CHKSUM_EN
      sum       <= '0;
`endif
    end else begin
      WE <= 1'b0;
      if (state == ST_LEN) begin
`ifdef MY_PROGLOADER_CHKSUM_EN
        sum <= '0;
`endif
        if (IN_VALID) begin
          remaining <= IN_DATA;
          next_addr <= '0;
        end
      end
      if (state == ST_DATA && IN_VALID) begin
        WE        <= 1'b1;
        WADDR     <= next_addr;
        WDATA     <= IN_DATA;
        next_addr <= next_addr + ADDR_W'(1);
        remaining <= remaining - 8'd1;
`ifdef MY_PROGLOADER_CHKSUM_EN
        sum       <= sum + IN_DATA;
`endif
      end
    end
  end

endmodule

// File: tb/tb_my_progloader.sv
// Self-checking bench for my_progloader: cycle vector table for a full load plus directed corner sequences.
module tb_my_progloader;

  logic       CK = 1'b0;
  logic       RST_N = 1'b1;
  logic       START = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_READY, WE, BUSY, CPU_RUN, ERR;
  logic [5:0] WADDR;
  logic [7:0] WDATA;

  my_progloader #(.MEM_BYTES(64), .ADDR_W(6)) dut (
    .CK(CK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(IN_READY), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .BUSY(BUSY), .CPU_RUN(CPU_RUN), .ERR(ERR)
  );

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model and write log fed from the write strobe.
  logic [7:0] tb_mem   [64];
  logic [7:0] log_addr [256];
  logic [7:0] log_data [256];
  int         we_count = 0;

  always @(posedge CK) begin
    if (WE === 1'b1) begin
      tb_mem[WADDR]             <= WDATA;
      log_addr[we_count % 256]  <= 8'(WADDR);
      log_data[we_count % 256]  <= WDATA;
      we_count                  <= we_count + 1;
    end
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [18:0] exp;
  } vec_t;

  vec_t       vecs [14];
  logic [7:0] img  [10];
  logic [7:0] exp_bytes [16];

  function automatic logic [18:0] outs(input logic rdy, input logic we, input logic [5:0] addr,
                                       input logic [7:0] wd, input logic busy, input logic run,
                                       input logic err);
    return {rdy, we, addr, wd, busy, run, err};
  endfunction

  function automatic logic [18:0] dut_outs();
    return {IN_READY, WE, WADDR, WDATA, BUSY, CPU_RUN, ERR};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic start_load();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Present one byte until accepted, bounded; optionally hold START alongside it.
  task automatic send_byte(input logic [7:0] d, input logic s);
    int unsigned k;
    k        = 0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    START    = s;
    while (IN_READY !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (IN_READY !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got ready=%0b expected 1", IN_READY);
    end
    step();
    IN_VALID = 1'b0;
    START    = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] sum);
`ifdef MY_PROGLOADER_CHKSUM_EN
    send_byte(~sum + 8'd1, 1'b0);
`else
    if (sum === 8'hxx) $display("unreachable");
`endif
  endtask

  task automatic check_writes(input string name, input int base, input int n);
    check({name, "_count"}, 32'(we_count - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      check({name, "_addr"}, 32'(log_addr[(base + i) % 256]), 32'(i));
      check({name, "_data"}, 32'(log_data[(base + i) % 256]), 32'(exp_bytes[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] lens [3];
    img = '{8'h0E, 8'hCB, 8'h09, 8'hEA, 8'h05, 8'h24, 8'h01, 8'hA1, 8'h04, 8'hA4};

    vecs[0] = '{1'b1, 1'b0, 8'h00, outs(1, 0, 0, 8'h00, 1, 0, 0)};
    vecs[1] = '{1'b0, 1'b1, 8'h0A, outs(1, 0, 0, 8'h00, 1, 0, 0)};
    for (int k = 0; k < 10; k++)
      vecs[2 + k] = '{1'b0, 1'b1, img[k], outs(1, 1, 6'(k), img[k], 1, 0, 0)};
`ifndef MY_PROGLOADER_CHKSUM_EN
    vecs[11].exp = outs(0, 1, 6'd9, 8'hA4, 0, 1, 0);
`endif
    // Record 12 carries the checksum in the checksum build and is ignored otherwise.
    vecs[12] = '{1'b0, 1'b1, 8'hC1, outs(0, 0, 6'd9, 8'hA4, 0, 1, 0)};
    vecs[13] = '{1'b0, 1'b1, 8'hFF, outs(0, 0, 6'd9, 8'hA4, 0, 1, 0)};

    #2 RST_N = 1'b0;
    step();
    step();
    check("reset_outputs", 32'(dut_outs()), 32'(0));
    RST_N = 1'b1;
    IN_VALID = 1'b1;
    step();
    check("idle_no_ready", 32'({IN_READY, BUSY, WE}), 32'(0));
    IN_VALID = 1'b0;

    base = we_count;
    for (int i = 0; i < 14; i++) begin
      START    = vecs[i].start;
      IN_VALID = vecs[i].valid;
      IN_DATA  = vecs[i].data;
      step();
      check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vecs[i].exp));
    end
    IN_VALID = 1'b0;
    check("mem_word0", 32'({tb_mem[0], tb_mem[1]}), 32'h0ECB);
    for (int i = 0; i < 10; i++) exp_bytes[i] = img[i];
    check_writes("full", base, 10);

    lens = '{8'd0, 8'd3, 8'd66};
    for (int i = 0; i < 3; i++) begin
      base = we_count;
      start_load();
      check($sformatf("len%0d_start", i), 32'({IN_READY, ERR, CPU_RUN}), 32'b100);
      send_byte(lens[i], 1'b0);
      check($sformatf("len%0d_fail", i), 32'({ERR, CPU_RUN, IN_READY, BUSY}), 32'b1000);
      step();
      check($sformatf("len%0d_nowrite", i), 32'(we_count - base), 32'(0));
    end
    start_load();
    check("fail_cleared", 32'({ERR, IN_READY}), 32'b01);

    base = we_count;
    send_byte(8'd10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      send_byte(img[k], 1'b0);
      step();
    end
    send_chk(8'h3F);
    check("gap_done", 32'({CPU_RUN, ERR}), 32'b10);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h55;
    for (int k = 0; k < 5; k++) step();
    IN_VALID = 1'b0;
    check("after_done_ready", 32'({IN_READY, CPU_RUN}), 32'b01);
    check_writes("gap", base, 10);

    start_load();
    check("restart_from_done", 32'({CPU_RUN, IN_READY}), 32'b01);
    base = we_count;
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h44;
    send_byte(8'd4, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    send_chk(8'hAA);
    step();
    check("start_in_data_done", 32'({CPU_RUN, BUSY}), 32'b10);
    check_writes("start_in_data", base, 4);

    start_load();
    send_byte(8'd10, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(img[k], 1'b0);
    #2 RST_N = 1'b0;
    #1;
    check("async_reset_outputs", 32'(dut_outs()), 32'(0));
    step();
    RST_N    = 1'b1;
    IN_VALID = 1'b1;
    step();
    check("reset_idle", 32'({IN_READY, BUSY}), 32'(0));
    IN_VALID = 1'b0;
    base = we_count;
    start_load();
    exp_bytes[0] = 8'hAA; exp_bytes[1] = 8'hBB;
    send_byte(8'd2, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_chk(8'h65);
    step();
    check("reload_done", 32'({CPU_RUN, ERR}), 32'b10);
    check_writes("reload", base, 2);

`ifdef MY_PROGLOADER_CHKSUM_EN
    exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h02;
    for (int i = 0; i < 2; i++) begin
      base = we_count;
      start_load();
      send_byte(8'd2, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      check($sformatf("chk%0d_busy", i), 32'({IN_READY, BUSY, CPU_RUN}), 32'b110);
      send_byte((i == 0) ? 8'hFD : 8'hFC, 1'b0);
      check($sformatf("chk%0d_result", i), 32'({CPU_RUN, ERR}), (i == 0) ? 32'b10 : 32'b01);
      step();
      check_writes($sformatf("chk%0d", i), base, 2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
